// File: rtl/conv_frame_builder_if.sv
// Handshake bundle for conv_frame_builder: pair input side and frame output side.
// The master modport is the source/sink environment, the slave modport is the builder.
interface conv_frame_builder_if #(
   parameter int FRAME_W = 276
) ();
   logic               i_code_rate;
   logic               i_valid;
   logic [1:0]         i_data;
   logic               i_last;
   logic               o_ready;
   logic [FRAME_W-1:0] o_frame;
   logic               o_frame_valid;
   logic               i_frame_ready;
   logic               o_last;

   modport master (
      output i_code_rate, i_valid, i_data, i_last, i_frame_ready,
      input  o_ready, o_frame, o_frame_valid, o_last
   );

   modport slave (
      input  i_code_rate, i_valid, i_data, i_last, i_frame_ready,
      output o_ready, o_frame, o_frame_valid, o_last
   );
endinterface

// File: rtl/conv_frame_builder.sv
// K=3 convolutional encoder (rate 1/2 or 1/3) packing coded bits MSB-first into
// FRAME_W-bit frames, with K-1 zero tail, zero padding and a valid/ready frame hand-off.
//
// state  | meaning
// S_FILL | accepting info pairs into the current frame
// S_TAIL | encoding the zero tail pair, then closing the final frame
// S_EMIT | frame presented downstream, held until i_frame_ready
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module conv_frame_builder #(
   parameter int         FRAME_W = 276,
   parameter logic [2:0] G0      = 3'b111,
   parameter logic [2:0] G1      = 3'b101,
   parameter logic [2:0] G2      = 3'b101
) (
   input logic                 clk,
   input logic                 rst,
   conv_frame_builder_if.slave bus
);
   localparam int PW = $clog2(FRAME_W);
   localparam logic [PW-1:0] P_TOP = PW'(FRAME_W - 1);

   typedef enum logic [1:0] {S_FILL, S_TAIL, S_EMIT} state_t;

   state_t             state_q, state_d;
   logic [FRAME_W-1:0] frame_q;
   logic [PW-1:0]      ptr_q;
   logic [1:0]         sr_q;
   logic               rate3_q;
   logic               last_q;
   logic               tail_pending_q;

   logic               ready;
   logic               accept;
   logic               do_tail;
   logic               hs;
   logic               set_tail;
   logic               first;
   logic               rate_in;
   logic               rate_eff;
   logic               rate_wr;
   logic               full_now;
   logic [1:0]         enc_d;
   logic [2:0]         r0, r1;
   logic [3:0]         code4;
   logic [5:0]         code6;
   logic [FRAME_W-1:0] ins;
   logic [PW-1:0]      step;

   assign first    = (ptr_q == P_TOP);
   assign rate_in  = (bus.i_code_rate == `CODE_RATE_3);
   assign rate_eff = first ? rate_in : rate3_q;
   assign full_now = (ptr_q == (rate_eff ? PW'(5) : PW'(3)));

   always_comb begin
      state_d  = state_q;
      ready    = 1'b0;
      accept   = 1'b0;
      do_tail  = 1'b0;
      hs       = 1'b0;
      set_tail = 1'b0;
      case (state_q)
         S_FILL: begin
            ready  = ~rst;
            accept = bus.i_valid & ready;
            if (accept) begin
               if (full_now) begin
                  state_d  = S_EMIT;
                  set_tail = bus.i_last;
               end else if (bus.i_last) begin
                  state_d = S_TAIL;
               end
            end
         end
         S_TAIL: begin
            do_tail = 1'b1;
            state_d = S_EMIT;
         end
         S_EMIT: begin
            if (bus.i_frame_ready) begin
               hs      = 1'b1;
               state_d = tail_pending_q ? S_TAIL : S_FILL;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   // Two bits per cycle: b0 sees the stored state, b1 sees b0 shifted in.
   always_comb begin
      enc_d   = do_tail ? 2'b00 : bus.i_data;
      r0      = {enc_d[0], sr_q};
      r1      = {enc_d[1], enc_d[0], sr_q[1]};
      code4   = {^(r0 & G0), ^(r0 & G1), ^(r1 & G0), ^(r1 & G1)};
      code6   = {^(r0 & G0), ^(r0 & G1), ^(r0 & G2), ^(r1 & G0), ^(r1 & G1), ^(r1 & G2)};
      rate_wr = do_tail ? rate3_q : rate_eff;
      step    = rate_wr ? PW'(6) : PW'(4);
      ins     = rate_wr ? {code6, {(FRAME_W-6){1'b0}}} : {code4, {(FRAME_W-4){1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FILL;
      end else begin
         state_q <= state_d;
      end
   end

   // Frame bits at and below the pointer are always zero, so OR-ing in is enough.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_q        <= '0;
         ptr_q          <= P_TOP;
         sr_q           <= 2'b00;
         rate3_q        <= 1'b0;
         last_q         <= 1'b0;
         tail_pending_q <= 1'b0;
      end else begin
         if (accept || do_tail) begin
            frame_q <= frame_q | (ins >> (P_TOP - ptr_q));
            ptr_q   <= ptr_q - step;
         end
         if (accept) begin
            sr_q <= bus.i_data;
            if (first) rate3_q <= rate_in;
         end
         if (do_tail) begin
            sr_q   <= 2'b00;
            last_q <= 1'b1;
         end
         if (set_tail) tail_pending_q <= 1'b1;
         if (hs) begin
            frame_q        <= '0;
            ptr_q          <= P_TOP;
            last_q         <= 1'b0;
            tail_pending_q <= 1'b0;
         end
      end
   end

   assign bus.o_ready       = ready;
   assign bus.o_frame       = frame_q;
   assign bus.o_frame_valid = (state_q == S_EMIT) && !rst;
   assign bus.o_last        = last_q;
endmodule

// File: tb/tb_conv_frame_builder.sv
// Randomized bench for conv_frame_builder against a bit-stream reference model:
// coded bits are appended to a queue and cut into MSB-first frames.
`ifndef CODE_RATE_2
`define CODE_RATE_2 1'b0
`endif
`ifndef CODE_RATE_3
`define CODE_RATE_3 1'b1
`endif

module tb_conv_frame_builder;
   localparam int         FW = 276;
   localparam logic [2:0] G0 = 3'b111;
   localparam logic [2:0] G1 = 3'b101;
   localparam logic [2:0] G2 = 3'b101;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   conv_frame_builder_if #(.FRAME_W(FW)) bus ();

   conv_frame_builder #(.FRAME_W(FW), .G0(G0), .G1(G1), .G2(G2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Reference model: plain bit queue, one frame pushed every FW coded bits.
   bit          mq[$];
   bit [FW-1:0] exp_f[$];
   bit          exp_l[$];
   bit          h1, h0;
   bit          m_r3;

   function automatic void m_bit(input bit b);
      bit [2:0] r;
      r = {b, h1, h0};
      mq.push_back(^(r & G0));
      mq.push_back(^(r & G1));
      if (m_r3) mq.push_back(^(r & G2));
      h0 = h1;
      h1 = b;
   endfunction

   function automatic void m_flush(input bit last);
      bit [FW-1:0] f;
      f = '0;
      foreach (mq[i]) f[FW-1-i] = mq[i];
      exp_f.push_back(f);
      exp_l.push_back(last);
      mq.delete();
   endfunction

   function automatic void m_accept(input bit [1:0] d, input bit last, input bit r3);
      if (mq.size() == 0) m_r3 = r3;
      m_bit(d[0]);
      m_bit(d[1]);
      if (mq.size() == FW) m_flush(1'b0);
      if (last) begin
         m_bit(1'b0);
         m_bit(1'b0);
         m_flush(1'b1);
         h1 = 1'b0;
         h0 = 1'b0;
      end
   endfunction

   function automatic void m_reset();
      mq.delete();
      exp_f.delete();
      exp_l.delete();
      h1 = 1'b0;
      h0 = 1'b0;
   endfunction

   // Frame sink and monitor: random ready, hold stability, model compare on handshake.
   bit          sink_en = 1'b0;
   bit          have_prev = 1'b0;
   bit [FW-1:0] prev_f;
   bit          prev_l;

   initial begin
      bus.i_frame_ready = 1'b0;
      forever begin
         @(negedge clk);
         bus.i_frame_ready = sink_en ? ($urandom_range(0, 3) != 0) : 1'b0;
         if (!rst && bus.o_frame_valid) begin
            if (have_prev) begin
               chk("hold_frame", bus.o_frame, prev_f);
               chk("hold_last", FW'(bus.o_last), FW'(prev_l));
            end
            if (bus.i_frame_ready) begin
               have_prev = 1'b0;
               if (exp_f.size() == 0) begin
                  chk("unexpected_frame", FW'(bus.o_frame_valid), '0);
               end else begin
                  chk("frame", bus.o_frame, exp_f.pop_front());
                  chk("frame_last", FW'(bus.o_last), FW'(exp_l.pop_front()));
               end
            end else begin
               have_prev = 1'b1;
               prev_f    = bus.o_frame;
               prev_l    = bus.o_last;
            end
         end else begin
            have_prev = 1'b0;
         end
      end
   end

   task automatic send_pair(input bit [1:0] d, input bit last, input bit r3);
      bus.i_valid     = 1'b1;
      bus.i_data      = d;
      bus.i_last      = last;
      bus.i_code_rate = r3 ? `CODE_RATE_3 : `CODE_RATE_2;
      for (int t = 0; t < 4000; t++) begin
         @(negedge clk);
         if (bus.o_ready) break;
      end
      chk("accept_ready", FW'(bus.o_ready), FW'(1));
      if (bus.o_ready) m_accept(d, last, r3);
      @(posedge clk);
      #1;
      bus.i_valid     = 1'b0;
      bus.i_last      = 1'b0;
      bus.i_code_rate = 1'($urandom_range(0, 1));
   endtask

   task automatic drain();
      sink_en = 1'b1;
      for (int t = 0; t < 20000; t++) begin
         @(posedge clk);
         if (exp_f.size() == 0) break;
      end
      chk("drain_empty", FW'(exp_f.size()), '0);
      repeat (2) @(posedge clk);
      #1;
      sink_en = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_ready"}, FW'(bus.o_ready), '0);
      chk({tag, "_valid"}, FW'(bus.o_frame_valid), '0);
      chk({tag, "_frame"}, bus.o_frame, '0);
      chk({tag, "_last"}, FW'(bus.o_last), '0);
   endtask

   task automatic single_pair_frame(input bit r3, input logic [FW-1:0] exp);
      send_pair(2'b01, 1'b1, r3);
      chk("lat_tail_cycle", FW'(bus.o_frame_valid), '0);
      @(posedge clk);
      #1;
      chk("lat_emit_cycle", FW'(bus.o_frame_valid), FW'(1));
      chk("short_frame", bus.o_frame, exp);
      chk("short_last", FW'(bus.o_last), FW'(1));
      drain();
   endtask

   initial begin
      logic [FW-1:0] exp_ec;
      logic [FW-1:0] exp_r3;
      bit            r3;
      int            len;
      exp_ec = {8'hEC, {(FW-8){1'b0}}};
      exp_r3 = {12'hF38, {(FW-12){1'b0}}};

      bus.i_valid     = 1'b0;
      bus.i_data      = 2'b00;
      bus.i_last      = 1'b0;
      bus.i_code_rate = `CODE_RATE_2;
      m_reset();

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst = 1'b0;
      #1;
      chk("ready_after_reset", FW'(bus.o_ready), FW'(1));

      // Rate 1/2, b0=1 b1=0 plus tail: 11 10 11 00.
      single_pair_frame(1'b0, exp_ec);
      // Rate 1/3 with (7,5,5): 111 100 111 000.
      single_pair_frame(1'b1, exp_r3);

      // 69 zero pairs fill a frame; hold the sink off for 10 cycles.
      for (int i = 0; i < 69; i++) send_pair(2'b00, 1'b0, 1'b0);
      chk("full_valid", FW'(bus.o_frame_valid), FW'(1));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("emit_ready", FW'(bus.o_ready), '0);
         chk("emit_valid", FW'(bus.o_frame_valid), FW'(1));
         chk("emit_frame", bus.o_frame, '0);
         chk("emit_last", FW'(bus.o_last), '0);
      end
      drain();

      // Last on the 69th pair: full frame, then a tail-only frame.
      sink_en = 1'b1;
      for (int i = 0; i < 69; i++) send_pair(2'($urandom_range(0, 3)), i == 68, 1'b0);
      drain();

      // Mid-frame reset discards everything; encoding restarts from zero state.
      for (int i = 0; i < 10; i++) send_pair(2'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)));
      rst = 1'b1;
      m_reset();
      @(posedge clk);
      #1;
      check_idle_outputs("midreset");
      rst = 1'b0;
      single_pair_frame(1'b0, exp_ec);

      // Random messages, rate toggled per pair (only a frame's first pair counts).
      sink_en = 1'b1;
      for (int m = 0; m < 12; m++) begin
         len = $urandom_range(1, 160);
         for (int i = 0; i < len; i++) begin
            r3 = 1'($urandom_range(0, 1));
            send_pair(2'($urandom_range(0, 3)), i == len - 1, r3);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
         end
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
